// File: rtl/sat_add_pkg.sv
// Shared types and helpers for the saturating add/subtract arbiter.
package sat_add_pkg;

    localparam int DATA_W  = 16;
    localparam int MAX_REQ = 4;
    localparam int TAG_W   = 2;

    localparam logic [DATA_W-1:0] SAT_POS = 16'h7FFF;
    localparam logic [DATA_W-1:0] SAT_NEG = 16'h8000;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b_eff;
        logic              cin;
        logic [TAG_W-1:0]  tag;
    } stage1_t;

    // First requester at or after ptr (modulo nreq) that is both valid and unmasked.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [TAG_W-1:0]   ptr,
        input logic [MAX_REQ-1:0] mask,
        input int unsigned        nreq
    );
        logic [MAX_REQ-1:0] pick;
        logic               found;
        logic [TAG_W-1:0]   idx;
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = TAG_W'((32'(ptr) + k) % nreq);
            if (k < nreq && !found && valid[idx] && mask[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/cla16_raw.sv
// Unsaturated 16-bit carry-lookahead adder: four 4-bit slices joined by
// group generate/propagate lookahead.
module cla16_raw
    import sat_add_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W-1:0] sum,
    output logic              cout
);

    logic [15:0] p;
    logic [15:0] g;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;

    assign p = a ^ b;
    assign g = a & b;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        gg = '0;
        gp = '0;
        gc = '0;
        c  = '0;
        for (int j = 0; j < 4; j++) begin
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | ((&p[4*j+1 +: 3]) & g[4*j]);
            gp[j] = &p[4*j +: 4];
        end
        gc[0] = cin;
        gc[1] = gg[0] | (gp[0] & cin);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & cin);
        gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
        for (int j = 0; j < 4; j++) begin
            c[4*j]   = gc[j];
            c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
        end
    end

    assign sum  = p ^ c;
    assign cout = gc[4];

endmodule

// File: rtl/sat_add_arbiter.sv
// Round-robin arbiter with bounded lock sharing one saturating add/subtract
// datapath; one stage of operands, one registered, tagged response.
module sat_add_arbiter
    import sat_add_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int LOCK_MAX = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        req_sub,
    input  logic [NREQ-1:0]        req_lock,
    input  logic [DATA_W*NREQ-1:0] req_a,
    input  logic [DATA_W*NREQ-1:0] req_b,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_sum,
    output logic                   rsp_cout,
    output logic                   rsp_ovf,
    output logic                   busy
);

    localparam logic [3:0] LOCK_LIM = 4'(LOCK_MAX);

    logic [TAG_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              lock_vld_q, lock_vld_d;
    logic [TAG_W-1:0]  lock_owner_q, lock_owner_d;
    logic [3:0]        lock_cnt_q, lock_cnt_d;
    stage1_t           s1_q, s1_d;
    logic              busy_q, busy_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_sum_q, rsp_sum_d;
    logic              rsp_cout_q, rsp_cout_d;
    logic              rsp_ovf_q, rsp_ovf_d;

    logic [MAX_REQ-1:0] valid_w, owner_oh, pick;
    logic [NREQ-1:0]    grant;
    logic [TAG_W-1:0]   grant_idx;
    logic               grant_any, grant_lock, grant_sub, lock_active, lock_expired;
    logic [DATA_W-1:0]  sel_a, sel_b, raw_sum;
    logic               raw_cout, sat_ovf;

    assign lock_active  = lock_vld_q && (lock_cnt_q < LOCK_LIM);
    assign lock_expired = lock_vld_q && (lock_cnt_q >= LOCK_LIM);

    // An expired owner sits out one arbitration unless nobody else wants the adder.
    always_comb begin
        valid_w  = MAX_REQ'(req_valid);
        owner_oh = '0;
        owner_oh[lock_owner_q] = 1'b1;
        pick     = '0;
        if (lock_active && ((valid_w & owner_oh) != '0)) begin
            pick = owner_oh;
        end else if (lock_expired) begin
            pick = rr_pick(valid_w, rr_ptr_q, ~owner_oh, NREQ);
            if (pick == '0) pick = rr_pick(valid_w, rr_ptr_q, '1, NREQ);
        end else begin
            pick = rr_pick(valid_w, rr_ptr_q, '1, NREQ);
        end
        grant     = pick[NREQ-1:0];
        grant_any = |grant;
        grant_idx = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                grant_idx = TAG_W'(i);
                sel_a     = req_a[DATA_W*i +: DATA_W];
                sel_b     = req_b[DATA_W*i +: DATA_W];
            end
        end
        grant_lock = |(grant & req_lock);
        grant_sub  = |(grant & req_sub);
    end

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        lock_vld_d   = 1'b0;
        lock_owner_d = '0;
        lock_cnt_d   = '0;
        s1_d         = s1_q;
        busy_d       = grant_any;
        if (grant_any) begin
            rr_ptr_d   = (grant_idx == TAG_W'(NREQ-1)) ? '0 : grant_idx + 1'b1;
            s1_d.a     = sel_a;
            s1_d.b_eff = grant_sub ? ~sel_b : sel_b;
            s1_d.cin   = grant_sub;
            s1_d.tag   = grant_idx;
            if (grant_lock) begin
                lock_vld_d   = 1'b1;
                lock_owner_d = grant_idx;
                lock_cnt_d   = (lock_active && lock_owner_q == grant_idx) ? lock_cnt_q + 4'd1 : 4'd1;
            end
        end
    end

    cla16_raw u_cla (
        .a    (s1_q.a),
        .b    (s1_q.b_eff),
        .cin  (s1_q.cin),
        .sum  (raw_sum),
        .cout (raw_cout)
    );

    always_comb begin
        sat_ovf = (s1_q.a[DATA_W-1] == s1_q.b_eff[DATA_W-1]) &&
                  (raw_sum[DATA_W-1] != s1_q.a[DATA_W-1]);
        rsp_valid_d = '0;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_ovf_d   = rsp_ovf_q;
        if (busy_q) begin
            for (int i = 0; i < NREQ; i++) begin
                if (s1_q.tag == TAG_W'(i)) rsp_valid_d[i] = 1'b1;
            end
            rsp_cout_d = raw_cout;
            rsp_ovf_d  = sat_ovf;
            rsp_sum_d  = !sat_ovf ? raw_sum : (s1_q.a[DATA_W-1] ? SAT_NEG : SAT_POS);
        end
    end

    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            lock_vld_q   <= 1'b0;
            lock_owner_q <= '0;
            lock_cnt_q   <= '0;
            s1_q         <= '0;
            busy_q       <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_sum_q    <= '0;
            rsp_cout_q   <= 1'b0;
            rsp_ovf_q    <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            lock_vld_q   <= lock_vld_d;
            lock_owner_q <= lock_owner_d;
            lock_cnt_q   <= lock_cnt_d;
            s1_q         <= s1_d;
            busy_q       <= busy_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_sum_q    <= rsp_sum_d;
            rsp_cout_q   <= rsp_cout_d;
            rsp_ovf_q    <= rsp_ovf_d;
        end
    end

    assign req_ready = grant;
    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_ovf   = rsp_ovf_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sat_add_arbiter.sv
// Scoreboard bench for sat_add_arbiter: grants checked per cycle, responses
// predicted from a signed-integer reference model and matched one cycle later.
module tb_sat_add_arbiter;

    localparam int NREQ     = 2;
    localparam int LOCK_MAX = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid, req_ready, req_sub, req_lock, rsp_valid;
    logic [16*NREQ-1:0]   req_a, req_b;
    logic [15:0]          rsp_sum;
    logic                 rsp_cout, rsp_ovf, busy;

    typedef struct {
        logic [NREQ-1:0] vld;
        logic [15:0]     sum;
        logic            cout;
        logic            ovf;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sat_add_arbiter #(.NREQ(NREQ), .LOCK_MAX(LOCK_MAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sub   (req_sub),
        .req_lock  (req_lock),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf),
        .busy      (busy)
    );

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic sub, input int tag);
        exp_t        e;
        int          sa, sb, r;
        logic [16:0] u;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = sub ? sa - sb : sa + sb;
        u  = {1'b0, a} + {1'b0, (sub ? ~b : b)} + 17'(sub);
        e.vld  = NREQ'(1) << tag;
        e.cout = u[16];
        e.ovf  = (r > 32767) || (r < -32768);
        e.sum  = (r > 32767) ? 16'h7FFF : (r < -32768) ? 16'h8000 : 16'(r);
        return e;
    endfunction

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b, input logic sub);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
        req_sub[i]        = sub;
    endtask

    function automatic logic [15:0] pick_operand();
        logic [15:0] corners [5];
        corners = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0001};
        return ($urandom_range(0, 1) == 0) ? corners[$urandom_range(0, 4)] : 16'($urandom());
    endfunction

    task automatic renew_operands(input logic [NREQ-1:0] acc);
        for (int i = 0; i < NREQ; i++)
            if (acc[i]) set_op(i, pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
    endtask

    // Advances one cycle: predicts accepts before the edge, checks the response after it.
    task automatic clock_and_score();
        exp_t            pend[$];
        exp_t            e;
        logic [NREQ-1:0] acc;
        #1;
        acc = req_valid & req_ready;
        for (int i = 0; i < NREQ; i++)
            if (acc[i]) pend.push_back(model(req_a[16*i +: 16], req_b[16*i +: 16], req_sub[i], i));
        @(posedge clk);
        #1;
        checks++;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (rsp_valid !== e.vld || rsp_sum !== e.sum || rsp_cout !== e.cout || rsp_ovf !== e.ovf) begin
                failures++;
                $display("FAIL rsp: got valid=%b sum=%h cout=%b ovf=%b, want valid=%b sum=%h cout=%b ovf=%b",
                         rsp_valid, rsp_sum, rsp_cout, rsp_ovf, e.vld, e.sum, e.cout, e.ovf);
            end
        end else if (rsp_valid !== '0) begin
            failures++;
            $display("FAIL rsp_idle: got rsp_valid=%b, want 0", rsp_valid);
        end
        foreach (pend[k]) sb_q.push_back(pend[k]);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '0; req_lock = '0; req_sub = '0; req_a = '0; req_b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({rsp_valid, rsp_sum, rsp_cout, rsp_ovf, busy, req_ready} !== '0) begin
            failures++;
            $display("FAIL reset_state: got valid=%b sum=%h cout=%b ovf=%b busy=%b ready=%b, want all 0",
                     rsp_valid, rsp_sum, rsp_cout, rsp_ovf, busy, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] gnt_t [4];
        logic [NREQ-1:0] acc;
        gnt_t = '{2'b01, 2'b10, 2'b01, 2'b10};
        set_op(0, 16'h0100, 16'h0023, 1'b0);
        set_op(1, 16'h0F00, 16'h0100, 1'b1);
        req_valid = 2'b11; req_lock = '0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (req_ready !== gnt_t[c]) begin
                failures++;
                $display("FAIL rr_grant[%0d]: got %b, want %b", c, req_ready, gnt_t[c]);
            end
            acc = req_valid & req_ready;
            clock_and_score();
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL rr_busy[%0d]: got %b, want 1", c, busy);
            end
            renew_operands(acc);
        end
        req_valid = '0;
        clock_and_score();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL rr_busy_drain: got %b, want 0", busy);
        end
    endtask

    task automatic test_lock_limit();
        logic [NREQ-1:0] gnt_t  [8];
        logic            lock_t [8];
        logic [NREQ-1:0] acc;
        gnt_t  = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};
        lock_t = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        req_valid = 2'b11;
        for (int c = 0; c < 8; c++) begin
            req_lock = {1'b0, lock_t[c]};
            #1;
            checks++;
            if (req_ready !== gnt_t[c]) begin
                failures++;
                $display("FAIL lock_limit[%0d]: got %b, want %b", c, req_ready, gnt_t[c]);
            end
            acc = req_valid & req_ready;
            clock_and_score();
            renew_operands(acc);
        end
        req_valid = '0; req_lock = '0;
        clock_and_score();
    endtask

    task automatic test_single_add();
        set_op(0, 16'h1234, 16'h0011, 1'b0);
        req_valid = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            failures++;
            $display("FAIL add_grant: got %b, want 01", req_ready);
        end
        clock_and_score();
        req_valid = '0;
        clock_and_score();
        checks++;
        if (rsp_valid !== 2'b01 || rsp_sum !== 16'h1245 || rsp_cout !== 1'b0 || rsp_ovf !== 1'b0) begin
            failures++;
            $display("FAIL add_result: got valid=%b sum=%h cout=%b ovf=%b, want 01 1245 0 0",
                     rsp_valid, rsp_sum, rsp_cout, rsp_ovf);
        end
        clock_and_score();
    endtask

    task automatic test_saturate();
        set_op(0, 16'h8000, 16'h0001, 1'b1);
        req_valid = 2'b01;
        clock_and_score();
        req_valid = '0;
        clock_and_score();
        checks++;
        if (rsp_valid !== 2'b01 || rsp_sum !== 16'h8000 || rsp_cout !== 1'b1 || rsp_ovf !== 1'b1) begin
            failures++;
            $display("FAIL neg_sat: got valid=%b sum=%h cout=%b ovf=%b, want 01 8000 1 1",
                     rsp_valid, rsp_sum, rsp_cout, rsp_ovf);
        end
        clock_and_score();
        checks++;
        if (req_ready !== '0) begin
            failures++;
            $display("FAIL idle_ready: got %b, want 00", req_ready);
        end
        // Pointer sat at 1 through the idle cycles, so requester 1 wins the tie.
        set_op(1, 16'h7000, 16'h2000, 1'b0);
        set_op(0, 16'h0005, 16'h0003, 1'b1);
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            failures++;
            $display("FAIL ptr_hold: got %b, want 10", req_ready);
        end
        clock_and_score();
        req_valid = 2'b01;
        clock_and_score();
        checks++;
        if (rsp_valid !== 2'b10 || rsp_sum !== 16'h7FFF || rsp_cout !== 1'b0 || rsp_ovf !== 1'b1) begin
            failures++;
            $display("FAIL pos_sat: got valid=%b sum=%h cout=%b ovf=%b, want 10 7fff 0 1",
                     rsp_valid, rsp_sum, rsp_cout, rsp_ovf);
        end
        req_valid = '0;
        clock_and_score();
    endtask

    task automatic test_lock_regrant();
        logic [NREQ-1:0] vld_t [9];
        logic [NREQ-1:0] gnt_t [9];
        logic [NREQ-1:0] acc;
        vld_t = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11};
        gnt_t = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
        req_lock = 2'b01;
        for (int c = 0; c < 9; c++) begin
            req_valid = vld_t[c];
            #1;
            checks++;
            if (req_ready !== gnt_t[c]) begin
                failures++;
                $display("FAIL lock_regrant[%0d]: got %b, want %b", c, req_ready, gnt_t[c]);
            end
            acc = req_valid & req_ready;
            clock_and_score();
            renew_operands(acc);
        end
        req_valid = '0; req_lock = '0;
        clock_and_score();
    endtask

    task automatic test_idle_release();
        logic [NREQ-1:0] vld_t [7];
        logic [NREQ-1:0] gnt_t [7];
        logic [NREQ-1:0] acc;
        vld_t = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
        gnt_t = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
        req_lock = 2'b01;
        for (int c = 0; c < 7; c++) begin
            req_valid = vld_t[c];
            #1;
            checks++;
            if (req_ready !== gnt_t[c]) begin
                failures++;
                $display("FAIL idle_release[%0d]: got %b, want %b", c, req_ready, gnt_t[c]);
            end
            acc = req_valid & req_ready;
            clock_and_score();
            renew_operands(acc);
        end
        req_valid = '0; req_lock = '0;
        clock_and_score();
    endtask

    task automatic test_back_to_back();
        logic [NREQ-1:0] acc;
        for (int c = 0; c < 60; c++) begin
            req_valid = NREQ'($urandom());
            req_lock  = NREQ'($urandom());
            #1;
            checks++;
            if (((req_ready & ~req_valid) !== '0) || !$onehot0(req_ready) ||
                ((req_valid != '0) && (req_ready == '0))) begin
                failures++;
                $display("FAIL b2b_grant[%0d]: got ready=%b for valid=%b", c, req_ready, req_valid);
            end
            acc = req_valid & req_ready;
            clock_and_score();
            renew_operands(acc);
        end
        req_valid = '0; req_lock = '0;
        repeat (2) clock_and_score();
    endtask

    task automatic test_reset_midflight();
        set_op(0, 16'h4321, 16'h1111, 1'b0);
        req_valid = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            failures++;
            $display("FAIL midflight_grant: got %b, want 01", req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0; req_valid = '0;
        @(posedge clk);
        #1;
        checks++;
        if ({rsp_valid, rsp_sum, rsp_cout, rsp_ovf, busy} !== '0) begin
            failures++;
            $display("FAIL midflight_reset: got valid=%b sum=%h cout=%b ovf=%b busy=%b, want all 0",
                     rsp_valid, rsp_sum, rsp_cout, rsp_ovf, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            failures++;
            $display("FAIL post_reset_grant: got %b, want 01", req_ready);
        end
        clock_and_score();
        req_valid = '0;
        repeat (2) clock_and_score();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_lock_limit();
        test_single_add();
        test_saturate();
        test_lock_regrant();
        test_idle_release();
        test_back_to_back();
        test_reset_midflight();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d responses never arrived, want 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sat_add_arbiter.md
Name: sat_add_arbiter

Overview:
Shares one 16-bit carry-lookahead add/subtract datapath between NREQ requesters, for example the execute-stage ALU and the reduction sequencer.
- Each requester issues operands with a valid/ready handshake.
- Grants are round-robin, with an optional bounded lock for multi-word operations.
- Each accepted request returns a registered, saturated result tagged back to that requester.

Parameters:
- NREQ, 2, number of requesters. Legal range 2..4.
- LOCK_MAX, 4, maximum consecutive grants one locked requester may hold before it must rotate. Legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active low.
- req_valid  in  NREQ  request i has operands present.
- req_ready  out  NREQ  grant vector; one-hot or zero; combinational from req_valid, the pointer and the lock state.
- req_sub  in  NREQ  1 = compute A-B, 0 = compute A+B.
- req_lock  in  NREQ  requester i asks to keep the grant on its next request.
- req_a  in  16*NREQ  operand A, requester i in bits [16i+15:16i].
- req_b  in  16*NREQ  operand B, same packing as req_a.
- rsp_valid  out  NREQ  one-cycle pulse: result belongs to requester i.
- rsp_sum  out  16  saturated result.
- rsp_cout  out  1  raw carry out of bit 15.
- rsp_ovf  out  1  signed overflow occurred (the result was saturated).
- busy  out  1  a stage-1 operation is in flight.

Behaviour:
- Reset: synchronous and active-low, sampled on the clk rising edge.
  - Clears: rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_ovf=0, busy=0, rr_ptr=0, lock_owner=none, lock_cnt=0, all stage-1 registers.
  - Reset mid-operation discards the in-flight result; no rsp_valid follows.
- Handshake: a request is accepted at an edge where req_valid[i] & req_ready[i]. A requester must hold its operands stable until accepted. Never back-pressured downstream; throughput is one request per cycle.
- Pipeline:
  - Edge E0: accepted operands are latched into stage 1 (a, b_eff=req_sub?~b:b, cin=req_sub, tag=i); busy=1.
  - Next cycle: the combinational CLA evaluates stage 1.
  - Edge E1: rsp_sum/rsp_cout/rsp_ovf are registered; rsp_valid[tag]=1 for exactly one cycle.
  - busy=0 after E1 unless a new request was accepted at E1.
  - Latency: accept edge to rsp_valid high is 1 cycle.
- Arithmetic:
  - raw = a + b_eff + cin, 16 bits; rsp_cout = carry out of bit 15.
  - Overflow is computed here from signs, never from any other adder flag: ovf = (a[15]==b_eff[15]) & (raw[15]!=a[15]).
  - Saturation: if ovf and a[15]==0, rsp_sum=0x7FFF; if ovf and a[15]==1, rsp_sum=0x8000; otherwise rsp_sum=raw.
- Arbitration, normal:
  - Search from rr_ptr upward, modulo NREQ; grant the first valid requester.
  - After a grant to g, rr_ptr <= (g+1) mod NREQ.
  - No valid requester: no grant, and the pointer holds.
- Arbitration, lock:
  - Accepting a grant with req_lock[g]=1 sets lock_owner=g and lock_cnt++.
  - While a lock is held and lock_cnt<LOCK_MAX, the owner is granted exclusively whenever it is valid.
  - If the owner is idle in a cycle, others may be granted, the lock is released and lock_cnt is cleared.
  - The lock is also released when the owner is accepted with req_lock=0.
  - When lock_cnt reaches LOCK_MAX, the lock is released and the owner is masked for one arbitration. Another valid requester wins; if none is valid, the owner may be granted again with lock_cnt restarting at 1.
- Simultaneous events: all NREQ valid in the same cycle gives exactly one grant. A new accept at E1 coexisting with the E1 response is legal and required for full throughput.
- req_ready is never asserted for a requester whose req_valid=0.

Decomposition:
- Package sat_add_pkg holds:
  - DATA_W=16, SAT_POS=16'h7FFF, SAT_NEG=16'h8000.
  - Typedef stage1_t {a, b_eff, cin, tag}.
  - Function rr_pick(valid, ptr, mask) returning a one-hot grant.
- One sub-module, cla16_raw: an unsaturated 16-bit CLA with four 4-bit lookahead slices and group generate/propagate, outputs Sum[15:0] and Cout. Saturation lives only in sat_add_arbiter.

Test Plan:
- Single add: req 0 issues A=0x1234, B=0x0011, sub=0 → next cycle rsp_valid=01, rsp_sum=0x1245, cout=0, ovf=0.
- Positive saturate: A=0x7000, B=0x2000 → rsp_sum=0x7FFF, ovf=1. Negative saturate: A=0x8000, req_sub=1, B=0x0001 → rsp_sum=0x8000, ovf=1, cout=1.
- Round-robin: both requesters valid for 4 cycles, no lock → grants 0,1,0,1; rsp_valid tags follow one cycle later; busy stays high throughout.
- Lock limit, LOCK_MAX=4: req 0 valid with lock=1 for 6 cycles and req 1 valid → grants 0,0,0,0,1,0.
- Reset mid-flight: rst_n low the cycle after an accept → no rsp_valid; all outputs 0; the first post-reset grant goes to req 0.
